// File: rtl/pentary_mem_pkg.sv
// Shared types and widths for the L1/L2 memory-side blocks.
package pentary_mem_pkg;

    localparam int PENTARY_ADDR_W = 48;
    localparam int PENTARY_LINE_W = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT-1.
module mem_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 request port between L1I and L1D: D-over-I priority
// with a starvation guard, one outstanding transaction, watchdog-bounded.
module l2_port_arbiter
    import pentary_mem_pkg::*;
#(
    parameter int ADDR_W       = PENTARY_ADDR_W,
    parameter int LINE_W       = PENTARY_LINE_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l1i_req,
    input  logic [ADDR_W-1:0] l1i_addr,
    output logic              l1i_ack,
    output logic [LINE_W-1:0] l1i_data,
    input  logic              l1d_read,
    input  logic              l1d_write,
    input  logic [ADDR_W-1:0] l1d_addr,
    input  logic [LINE_W-1:0] l1d_wdata,
    output logic              l1d_ack,
    output logic [LINE_W-1:0] l1d_data,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_read,
    output logic              l2_write,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic              err_timeout,
    output logic              busy
);

    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e              state_q,  state_d;
    owner_e              owner_q,  owner_d;
    op_e                 op_q,     op_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [LINE_W-1:0]   wdata_q,  wdata_d;
    logic [LINE_W-1:0]   rdata_q,  rdata_d;
    logic                err_q,    err_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic d_req;
    logic grant_i;
    logic wd_expire;

    // Counter is held at zero outside BUSY, so it always starts from 0 on entry.
    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != BUSY),
        .enable (state_q == BUSY),
        .expire (wd_expire)
    );

    assign d_req   = l1d_read | l1d_write;
    assign grant_i = l1i_req && (!d_req || (starve_q == STARVE_MAX));

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (l1i_req || d_req) begin
                    state_d = BUSY;
                    err_d   = 1'b0;
                    if (grant_i) begin
                        owner_d  = OWN_I;
                        op_d     = OP_RD;
                        addr_d   = l1i_addr;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_D;
                        op_d    = l1d_write ? OP_WR : OP_RD;
                        addr_d  = l1d_addr;
                        wdata_d = l1d_wdata;
                        if (l1i_req && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            BUSY: begin
                if (l2_ready) begin
                    state_d = DONE;
                    rdata_d = l2_rdata;
                end else if (wd_expire) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    // Outputs decode only registered state and latches.
    assign busy        = (state_q != IDLE);
    assign l2_read     = (state_q == BUSY) && (op_q == OP_RD);
    assign l2_write    = (state_q == BUSY) && (op_q == OP_WR);
    assign l2_addr     = addr_q;
    assign l2_wdata    = wdata_q;
    assign l1i_ack     = (state_q == DONE) && (owner_q == OWN_I);
    assign l1d_ack     = (state_q == DONE) && (owner_q == OWN_D);
    assign l1i_data    = l1i_ack ? rdata_q : '0;
    assign l1d_data    = l1d_ack ? rdata_q : '0;
    assign err_timeout = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_l2_port_arbiter;
    import pentary_mem_pkg::*;

    localparam int AW    = 48;
    localparam int LW    = 512;
    localparam int LIMIT = 4;
    localparam int TO    = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          l1i_req;
    logic [AW-1:0] l1i_addr;
    logic          l1i_ack;
    logic [LW-1:0] l1i_data;
    logic          l1d_read;
    logic          l1d_write;
    logic [AW-1:0] l1d_addr;
    logic [LW-1:0] l1d_wdata;
    logic          l1d_ack;
    logic [LW-1:0] l1d_data;
    logic [AW-1:0] l2_addr;
    logic          l2_read;
    logic          l2_write;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_ready;
    logic          err_timeout;
    logic          busy;

    l2_port_arbiter #(
        .ADDR_W       (AW),
        .LINE_W       (LW),
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .l1i_req     (l1i_req),
        .l1i_addr    (l1i_addr),
        .l1i_ack     (l1i_ack),
        .l1i_data    (l1i_data),
        .l1d_read    (l1d_read),
        .l1d_write   (l1d_write),
        .l1d_addr    (l1d_addr),
        .l1d_wdata   (l1d_wdata),
        .l1d_ack     (l1d_ack),
        .l1d_data    (l1d_data),
        .l2_addr     (l2_addr),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_wdata    (l2_wdata),
        .l2_rdata    (l2_rdata),
        .l2_ready    (l2_ready),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int starve_m = 0;
    int last_owner;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[AW-1:0];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_rd"},    l2_read, 0);
        check({tag, "_wr"},    l2_write, 0);
        check({tag, "_iack"},  l1i_ack, 0);
        check({tag, "_dack"},  l1d_ack, 0);
        check({tag, "_err"},   err_timeout, 0);
        check({tag, "_idata"}, l1i_data, 0);
        check({tag, "_ddata"}, l1d_data, 0);
    endtask

    // Issues one request pattern from IDLE, lets L2 answer in BUSY cycle k
    // (no answer if k exceeds TO) and checks the whole transaction.
    task automatic run_txn(input string tag, input bit ireq, input bit dread, input bit dwrite,
                           input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                           input logic [LW-1:0] wdata, input logic [LW-1:0] rdata, input int k);
        bit            win_i, is_wr, err;
        int            exp_len;
        logic [AW-1:0] exp_addr;
        l1i_req   = ireq;
        l1d_read  = dread;
        l1d_write = dwrite;
        l1i_addr  = iaddr;
        l1d_addr  = daddr;
        l1d_wdata = wdata;
        l2_ready  = 1'($urandom_range(0, 1));
        // Reference: D beats I unless I has been passed over LIMIT times in a row.
        win_i = ireq && (!(dread || dwrite) || starve_m == LIMIT);
        if (win_i) starve_m = 0;
        else if (ireq && starve_m < LIMIT) starve_m++;
        is_wr    = !win_i && dwrite;
        exp_addr = win_i ? iaddr : daddr;
        exp_len  = (k <= TO) ? k : TO;
        err      = (k > TO);
        tick();
        for (int c = 1; c <= exp_len; c++) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_l2rd"}, l2_read, !is_wr);
            check({tag, "_l2wr"}, l2_write, is_wr);
            check({tag, "_l2addr"}, l2_addr, exp_addr);
            if (is_wr) check({tag, "_l2wdata"}, l2_wdata, wdata);
            check({tag, "_noack"}, l1i_ack | l1d_ack, 0);
            l1i_addr = rand_addr();
            l1d_addr = rand_addr();
            l2_ready = (c == k);
            l2_rdata = (c == k) ? rdata : rand_line();
            tick();
        end
        l2_ready = 1'b0;
        check({tag, "_done_busy"}, busy, 1);
        check({tag, "_done_strobe"}, l2_read | l2_write, 0);
        check({tag, "_iack"}, l1i_ack, win_i);
        check({tag, "_dack"}, l1d_ack, !win_i);
        check({tag, "_err"}, err_timeout, err);
        if (win_i) begin
            check({tag, "_idata"}, l1i_data, err ? '0 : rdata);
            check({tag, "_ddata"}, l1d_data, 0);
        end else begin
            if (!is_wr) check({tag, "_ddata"}, l1d_data, err ? '0 : rdata);
            check({tag, "_idata"}, l1i_data, 0);
        end
        last_owner = l1d_ack ? 1 : 0;
        l1i_req   = 1'b0;
        l1d_read  = 1'b0;
        l1d_write = 1'b0;
        l2_ready  = 1'($urandom_range(0, 1));
        tick();
        l2_ready = 1'b0;
        check_zero({tag, "_idle"});
    endtask

    initial begin
        logic [LW-1:0] pat_a5, pat_5a;
        reset     = 1'b1;
        l1i_req   = 1'b0;
        l1i_addr  = '0;
        l1d_read  = 1'b0;
        l1d_write = 1'b0;
        l1d_addr  = '0;
        l1d_wdata = '0;
        l2_rdata  = '0;
        l2_ready  = 1'b0;
        pat_a5    = {64{8'hA5}};
        pat_5a    = {64{8'h5A}};

        tick();
        tick();
        check_zero("rst");
        check("rst_l2addr", l2_addr, 0);
        check("rst_l2wdata", l2_wdata, 0);
        reset = 1'b0;
        tick();
        check_zero("post_rst");

        // I-only read answered in the 3rd BUSY cycle.
        run_txn("t1", 1, 0, 0, 48'h0000_0000_1040, '0, '0, pat_a5, 3);

        // Both sides held: D,D,D,D,I repeating.
        for (int i = 0; i < 10; i++) begin
            run_txn("t2", 1, 1, 0, rand_addr(), rand_addr(), '0, rand_line(), 1);
            check("t2_pattern", last_owner, (i % 5 == 4) ? 0 : 1);
        end

        // Write wins over read on the D side.
        run_txn("t3", 0, 1, 1, '0, 48'h2000, pat_5a, rand_line(), 2);

        // Ready in the final watchdog cycle still succeeds; one later aborts.
        run_txn("t4_edge", 0, 1, 0, '0, rand_addr(), '0, rand_line(), TO);
        run_txn("t4_to", 0, 1, 0, '0, rand_addr(), '0, rand_line(), TO + 1);

        // Reset in the 2nd BUSY cycle, then the still-held request is re-granted.
        l1d_read = 1'b1;
        l1d_addr = 48'h3000;
        tick();
        check("t5_busy1", busy, 1);
        tick();
        check("t5_busy2", busy, 1);
        reset = 1'b1;
        tick();
        check_zero("t5_rst");
        check("t5_l2addr", l2_addr, 0);
        starve_m = 0;
        reset    = 1'b0;
        run_txn("t5_regrant", 0, 1, 0, '0, 48'h3000, '0, rand_line(), 2);

        // Randomized traffic with idle gaps and stray l2_ready pulses.
        for (int n = 0; n < 40; n++) begin
            bit ir, dr, dw;
            int k;
            do begin
                ir = 1'($urandom);
                dr = 1'($urandom);
                dw = 1'($urandom);
            end while (!(ir || dr || dw));
            k = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(1, 6));
            run_txn("rnd", ir, dr, dw, rand_addr(), rand_addr(), rand_line(), rand_line(), k);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                l2_ready = 1'($urandom);
                tick();
                check_zero("gap");
            end
            l2_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
